// File: rtl/hex_disp_pkg.sv
// Shared constants for the scanned seven-segment display: blank pattern,
// active-low glyph table for hex digits 0-F, and load_mode bit positions.
package hex_disp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} patterns, indexed by nibble value.
  localparam logic [6:0] GLYPHS [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  localparam int MODE_LZS   = 0;
  localparam int MODE_BLINK = 1;

endpackage

// File: rtl/hex_seg_decode.sv
// Combinational nibble to active-low segment lookup with a blank override.
module hex_seg_decode
  import hex_disp_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg_n
);

  assign seg_n = blank ? SEG_BLANK : GLYPHS[nibble];

endmodule

// File: rtl/hex_scan_display.sv
// Time-multiplexed hex display driver: one digit slot per SCAN_DIV cycles,
// new values are latched into a pending slot and only go live at a frame end.
module hex_scan_display
  import hex_disp_pkg::*;
#(
  parameter int NUM_DIGITS   = 6,
  parameter int SCAN_DIV     = 50000,
  parameter int DEAD_CYC     = 2,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic [1:0]              load_mode,
  output logic [6:0]              seg_n,
  output logic [NUM_DIGITS-1:0]   dig_n,
  output logic                    frame_done
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [PW-1:0]           presc;
  logic [IW-1:0]           idx;
  logic [BW-1:0]           blink_cnt;
  logic                    blink_phase;
  logic [4*NUM_DIGITS-1:0] active_data;
  logic [1:0]              active_mode;
  logic                    pend_valid;
  logic [4*NUM_DIGITS-1:0] pend_data;
  logic [1:0]              pend_mode;

  logic                    tick;
  logic                    frame_end;
  logic                    promote;
  logic                    accept;
  logic                    pend_valid_nxt;
  logic [3:0]              cur_nib;
  logic                    upper_nz;
  logic                    blank;
  logic [6:0]              seg_nxt;
  logic [NUM_DIGITS-1:0]   dig_nxt;

  assign tick      = (presc == PW'(SCAN_DIV - 1));
  assign frame_end = tick && (idx == IW'(NUM_DIGITS - 1));

  // Handshake: load_ready always mirrors an empty pending slot, so a transfer
  // and a promotion can never land in the same cycle.
  assign promote        = frame_end && pend_valid;
  assign accept         = load_valid && load_ready;
  assign pend_valid_nxt = accept || (pend_valid && !promote);

  // Current digit nibble, and whether any digit at or above it is non-zero.
  always_comb begin
    cur_nib  = 4'h0;
    upper_nz = 1'b0;
    dig_nxt  = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IW'(i) == idx) begin
        cur_nib = active_data[4*i +: 4];
        if (presc >= PW'(DEAD_CYC)) dig_nxt[i] = 1'b0;
      end
      if ((IW'(i) >= idx) && (active_data[4*i +: 4] != 4'h0)) upper_nz = 1'b1;
    end
  end

  assign blank = (active_mode[MODE_BLINK] && blink_phase) ||
                 (active_mode[MODE_LZS] && (idx != '0) && !upper_nz);

  hex_seg_decode u_dec (
    .nibble (cur_nib),
    .blank  (blank),
    .seg_n  (seg_nxt)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      presc       <= '0;
      idx         <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      active_data <= '0;
      active_mode <= '0;
      pend_valid  <= 1'b0;
      pend_data   <= '0;
      pend_mode   <= '0;
      seg_n       <= SEG_BLANK;
      dig_n       <= '1;
      frame_done  <= 1'b0;
      load_ready  <= 1'b1;
    end else begin
      if (tick) begin
        presc <= '0;
        idx   <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
      end else begin
        presc <= presc + PW'(1);
      end

      if (frame_end) begin
        if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
          blink_cnt   <= '0;
          blink_phase <= !blink_phase;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end

      if (promote) begin
        active_data <= pend_data;
        active_mode <= pend_mode;
      end else if (accept) begin
        pend_data <= load_data;
        pend_mode <= load_mode;
      end
      pend_valid <= pend_valid_nxt;

      seg_n      <= seg_nxt;
      dig_n      <= dig_nxt;
      frame_done <= frame_end;
      load_ready <= !pend_valid_nxt;
    end
  end

endmodule

// File: tb/tb_hex_scan_display.sv
// Bench for hex_scan_display (4 digits, 4-cycle slots, 1 dead cycle, 2-frame blink).
// The reference model derives frame, slot and blink phase from elapsed cycles.
module tb_hex_scan_display;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int DC = 1;
  localparam int BF = 2;
  localparam int FL = ND * SD;

  localparam logic [6:0] GLY [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic        clk = 1'b0;
  logic        resetn;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic [1:0]  load_mode;
  logic [6:0]  seg_n;
  logic [3:0]  dig_n;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  hex_scan_display #(
    .NUM_DIGITS(ND), .SCAN_DIV(SD), .DEAD_CYC(DC), .BLINK_FRAMES(BF)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_mode  (load_mode),
    .seg_n      (seg_n),
    .dig_n      (dig_n),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int          m_t;
  logic [15:0] m_active, m_pdata;
  logic [1:0]  m_mode, m_pmode;
  logic        m_pend;
  logic [6:0]  exp_seg;
  logic [3:0]  exp_dig;
  logic        exp_fd, exp_rdy;

  function automatic logic [6:0] model_seg(int t, logic [15:0] val, logic [1:0] mode);
    int slot  = (t % FL) / SD;
    int frame = t / FL;
    logic [3:0] nib = 4'(val >> (4 * slot));
    if (mode[1] && ((frame / BF) % 2 == 1)) return 7'h7F;
    if (mode[0] && slot != 0 && (val >> (4 * slot)) == 16'h0) return 7'h7F;
    return GLY[nib];
  endfunction

  function automatic logic [3:0] model_dig(int t);
    int slot = (t % FL) / SD;
    if ((t % SD) < DC) return 4'hF;
    return ~(4'b0001 << slot);
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_t      <= 0;
      m_active <= '0;
      m_mode   <= '0;
      m_pend   <= 1'b0;
      m_pdata  <= '0;
      m_pmode  <= '0;
      exp_seg  <= 7'h7F;
      exp_dig  <= 4'hF;
      exp_fd   <= 1'b0;
      exp_rdy  <= 1'b1;
    end else begin
      exp_seg <= model_seg(m_t, m_active, m_mode);
      exp_dig <= model_dig(m_t);
      exp_fd  <= ((m_t % FL) == FL - 1);
      if (((m_t % FL) == FL - 1) && m_pend) begin
        m_active <= m_pdata;
        m_mode   <= m_pmode;
        m_pend   <= 1'b0;
        exp_rdy  <= 1'b1;
      end else if (load_valid && !m_pend) begin
        m_pdata <= load_data;
        m_pmode <= load_mode;
        m_pend  <= 1'b1;
        exp_rdy <= 1'b0;
      end else begin
        exp_rdy <= !m_pend;
      end
      m_t <= m_t + 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_fd();
    do @(negedge clk); while (!exp_fd);
  endtask

  task automatic do_load(input logic [15:0] d, input logic [1:0] m);
    while (!exp_rdy) @(negedge clk);
    load_data  = d;
    load_mode  = m;
    load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  // Records the last segment pattern shown on each digit over one frame.
  task automatic observe_frame(output logic [6:0] seen [4], output int fds);
    logic [3:0] sel;
    for (int i = 0; i < 4; i++) seen[i] = 7'h55;
    fds = 0;
    for (int k = 1; k <= FL; k++) begin
      @(negedge clk);
      if (frame_done) fds++;
      for (int i = 0; i < 4; i++) begin
        sel = ~(4'b0001 << i);
        if (dig_n === sel) seen[i] = seg_n;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int got = -1;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (seg_n !== 7'h7F) begin errors++; $display("FAIL reset_seg got=%h exp=7f", seg_n); end
    checks++; if (dig_n !== 4'hF) begin errors++; $display("FAIL reset_dig got=%h exp=f", dig_n); end
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", load_ready); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd got=%b exp=0", frame_done); end
    resetn = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      checks++;
      if (dig_n !== exp_dig) begin errors++; $display("FAIL reset_scan_dig c=%0d got=%h exp=%h", c, dig_n, exp_dig); end
      if (frame_done === 1'b1) begin got = c; break; end
    end
    checks++; if (got != 16) begin errors++; $display("FAIL first_frame_done got=%0d exp=16", got); end
    if (!exp_fd) wait_fd();
  endtask

  task automatic test_basic_scan();
    logic [6:0] exp_s [4] = '{7'h0E, 7'h08, 7'h24, 7'h79};
    int slot, sub;
    do_load(16'h12AF, 2'b00);
    wait_fd();
    for (int c = 0; c < FL; c++) begin
      @(negedge clk);
      slot = c / SD;
      sub  = c % SD;
      checks++;
      if (dig_n !== ((sub < DC) ? 4'hF : ~(4'b0001 << slot)) || seg_n !== exp_s[slot] ||
          frame_done !== (c == FL - 1)) begin
        errors++;
        $display("FAIL basic_scan c=%0d got dig=%h seg=%h fd=%b exp seg=%h", c, dig_n, seg_n, frame_done, exp_s[slot]);
      end
    end
  endtask

  task automatic test_lzs();
    logic [6:0] seen [4];
    int fds;
    do_load(16'h0050, 2'b01);
    wait_fd();
    observe_frame(seen, fds);
    checks++;
    if (seen[0] !== 7'h40 || seen[1] !== 7'h12 || seen[2] !== 7'h7F || seen[3] !== 7'h7F) begin
      errors++;
      $display("FAIL lzs_0050 got d0=%h d1=%h d2=%h d3=%h exp 40 12 7f 7f", seen[0], seen[1], seen[2], seen[3]);
    end
    do_load(16'h0000, 2'b01);
    wait_fd();
    observe_frame(seen, fds);
    checks++;
    if (seen[0] !== 7'h40 || seen[1] !== 7'h7F || seen[2] !== 7'h7F || seen[3] !== 7'h7F) begin
      errors++;
      $display("FAIL lzs_0000 got d0=%h d1=%h d2=%h d3=%h exp 40 7f 7f 7f", seen[0], seen[1], seen[2], seen[3]);
    end
  endtask

  task automatic test_blink();
    logic [6:0] seen [4];
    logic [6:0] want;
    int fds, lit = 0;
    do_load(16'h1111, 2'b10);
    wait_fd();
    for (int f = 0; f < 4; f++) begin
      want = (((m_t / FL) / BF) % 2 == 0) ? 7'h79 : 7'h7F;
      observe_frame(seen, fds);
      if (want == 7'h79) lit++;
      checks++;
      if (seen[0] !== want || seen[1] !== want || seen[2] !== want || seen[3] !== want) begin
        errors++;
        $display("FAIL blink_frame f=%0d got %h %h %h %h exp %h", f, seen[0], seen[1], seen[2], seen[3], want);
      end
      checks++;
      if (fds != 1) begin errors++; $display("FAIL blink_frame_done f=%0d got=%0d exp=1", f, fds); end
    end
    checks++; if (lit != 2) begin errors++; $display("FAIL blink_lit_count got=%0d exp=2", lit); end
  endtask

  task automatic test_tear_free();
    wait_fd();
    repeat (5) @(negedge clk);
    load_data  = 16'h1234;
    load_mode  = 2'b00;
    load_valid = 1'b1;
    @(negedge clk);
    load_data  = 16'hABCD;
    while (!exp_fd) begin
      checks++;
      if (load_ready !== 1'b0 || seg_n !== exp_seg || dig_n !== exp_dig) begin
        errors++;
        $display("FAIL tear_hold got rdy=%b seg=%h dig=%h exp rdy=0 seg=%h dig=%h", load_ready, seg_n, dig_n, exp_seg, exp_dig);
      end
      @(negedge clk);
    end
    @(negedge clk);
    load_valid = 1'b0;
    for (int k = 2; k <= FL; k++) begin
      @(negedge clk);
      if (k >= 2 && k <= SD) begin
        checks++;
        if (dig_n !== 4'hE || seg_n !== 7'h19) begin
          errors++; $display("FAIL tear_new_d0 k=%0d got dig=%h seg=%h exp dig=e seg=19", k, dig_n, seg_n);
        end
      end
    end
    for (int k = 1; k <= SD; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        checks++;
        if (dig_n !== 4'hE || seg_n !== 7'h21) begin
          errors++; $display("FAIL tear_second_d0 k=%0d got dig=%h seg=%h exp dig=e seg=21", k, dig_n, seg_n);
        end
      end
    end
  endtask

  task automatic test_reset_pending();
    logic [6:0] seen [4];
    int fds;
    wait_fd();
    repeat (3) @(negedge clk);
    do_load(16'h9999, 2'b00);
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (seg_n !== 7'h7F || dig_n !== 4'hF || load_ready !== 1'b1 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_pending_outputs got seg=%h dig=%h rdy=%b fd=%b exp 7f f 1 0", seg_n, dig_n, load_ready, frame_done);
    end
    @(negedge clk);
    resetn = 1'b1;
    for (int f = 0; f < 2; f++) begin
      observe_frame(seen, fds);
      checks++;
      if (seen[0] !== 7'h40 || seen[1] !== 7'h40 || seen[2] !== 7'h40 || seen[3] !== 7'h40 || fds != 1) begin
        errors++;
        $display("FAIL reset_pending_frame f=%0d got %h %h %h %h fds=%0d exp 40 x4 fds=1", f, seen[0], seen[1], seen[2], seen[3], fds);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      checks++;
      if ({seg_n, dig_n, frame_done, load_ready} !== {exp_seg, exp_dig, exp_fd, exp_rdy}) begin
        errors++;
        $display("FAIL random_cycle t=%0d got seg=%h dig=%h fd=%b rdy=%b exp seg=%h dig=%h fd=%b rdy=%b",
                 m_t, seg_n, dig_n, frame_done, load_ready, exp_seg, exp_dig, exp_fd, exp_rdy);
      end
      load_valid = ($urandom_range(0, 5) == 0);
      load_data  = 16'($urandom);
      if ($urandom_range(0, 1) == 1) load_data[15:8] = 8'h00;
      load_mode  = 2'($urandom_range(0, 3));
    end
    load_valid = 1'b0;
  endtask

  initial begin
    resetn     = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    load_mode  = '0;
    test_reset();
    test_basic_scan();
    test_lzs();
    test_blink();
    test_tear_free();
    test_reset_pending();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hex_scan_display.md
# hex_scan_display

Parametrised, time-multiplexed seven-segment display driver, successor to the per-digit combinational HEX decoders. Accepts an N-digit hexadecimal value over a valid/ready handshake and scans it onto a shared active-low segment bus with one-hot active-low digit enables. Adds tear-free frame-boundary updates, leading-zero suppression, blinking and anti-ghosting dead time. Sits between the processor's debug/counter registers and the board display pins.

## Interface
- `NUM_DIGITS`, 6: digits driven; digit 0 is least significant; range 2–8.
- `SCAN_DIV`, 50000: clock cycles per digit slot; must be ≥ `DEAD_CYC`+2.
- `DEAD_CYC`, 2: cycles at the start of each slot with all digits disabled.
- `BLINK_FRAMES`, 64: frames per blink half-period; must be ≥ 1.
- `clk`, in, 1: single clock; all logic rising-edge.
- `resetn`, in, 1: asynchronous assert, active-low reset.
- `load_valid`, in, 1: `load_data`/`load_mode` offered.
- `load_ready`, out, 1: no update pending; transfer on `load_valid && load_ready`.
- `load_data`, in, 4*`NUM_DIGITS`: nibble i → digit i.
- `load_mode`, in, 2: bit0 = leading-zero suppress, bit1 = blink enable.
- `seg_n`, out, 7: active-low segments {g,f,e,d,c,b,a}.
- `dig_n`, out, `NUM_DIGITS`: active-low one-hot digit enable.
- `frame_done`, out, 1: one-cycle pulse at the end of each full scan.

## Operation
- Reset values:
  - `seg_n`=7'h7F, `dig_n`=all ones, `load_ready`=1, `frame_done`=0.
  - Active value and mode = 0; pending empty.
  - Prescaler, digit index and blink counter = 0; blink phase = 0.
- Glyphs 0–F:
  - 0–7: 40,79,24,30,19,12,02,78.
  - 8–F: 00,10,08,03,46,21,06,0E (hex).
  - Blank = 7F.
- Prescaler counts 0..`SCAN_DIV`-1; `tick` when it equals `SCAN_DIV`-1. Digit index advances on `tick` and wraps from `NUM_DIGITS`-1 to 0.
- Frame end = `tick` with index `NUM_DIGITS`-1.
  - `frame_done` asserts the following cycle.
  - Blink counter increments at each frame end; at `BLINK_FRAMES`-1 it wraps to 0 and toggles the blink phase.
- Handshake:
  - A transfer captures data and mode into the pending register; `load_ready` falls next cycle.
  - At a frame end, a pending entry that was already present before that cycle moves to the active registers; `load_ready` rises next cycle.
  - A transfer in the frame-end cycle itself waits for the next frame end.
  - `load_data` is never shown mid-frame.
- Digit i is blank if any of:
  - blink enabled and blink phase = 1;
  - suppress enabled, i ≠ 0, and active nibbles i..`NUM_DIGITS`-1 are all zero.
  - Digit 0 is never suppressed.
- `dig_n` is all ones while prescaler < `DEAD_CYC`; otherwise bit[index] = 0 and the others are 1. `seg_n` updates with the index.
- A reset mid-frame or mid-handshake discards the pending entry and returns everything to the reset values.

## Timing
- `seg_n`, `dig_n`, `frame_done` and `load_ready` are registered, with 1 cycle latency from internal state.
- Slot length is exactly `SCAN_DIV` cycles; frame length is `NUM_DIGITS`*`SCAN_DIV`.
- Worst-case load-to-display latency is one frame plus 2 cycles. Best case is 2 cycles after the frame end following capture.
- `load_ready` is independent of `load_valid` in the same cycle.
- `frame_done` pulses exactly once per frame, including while the display is blanked.

## Structure
- Package `hex_disp_pkg` holds:
  - `SEG_BLANK` = 7'h7F;
  - the 16-entry glyph constant array;
  - `MODE_LZS` = 0 and `MODE_BLINK` = 1 bit indices.
- Sub-module `hex_seg_decode` is a combinational nibble+blank → `seg_n` lookup, instantiated once on the muxed nibble.
- Everything else lives in the top: prescaler, scan, blink and handshake logic.

## Test plan
Bench parameters: `NUM_DIGITS`=4, `SCAN_DIV`=4, `DEAD_CYC`=1, `BLINK_FRAMES`=2.
- **Reset:** hold `resetn`=0 → `seg_n`=7F, `dig_n`=4'hF, `load_ready`=1. Release → first `frame_done` 16 cycles later.
- **Basic scan:** load 16'h12AF, mode 0 → slots show `dig_n`=E/D/B/7 with `seg_n`=0E/08/24/79. Each slot has 1 dead cycle with `dig_n`=F.
- **Leading-zero suppression:** load 16'h0050, mode 1 → digits 3 and 2 show 7F, digit 1 shows 12, digit 0 shows 40. Load 16'h0000 → only digit 0 shows 40.
- **Blink:** mode 2 with 16'h1111 → 2 frames lit (79), 2 frames all 7F, repeating; `frame_done` continues throughout.
- **Tear-free update:** load 16'h1234 mid-frame → `load_ready`=0 until the frame end and the current frame is unchanged. A second `load_valid` is held off; the new value appears only from digit 0 of the next frame.
- **Reset with pending entry:** pulse `resetn` low with an entry pending → pending dropped, outputs return to reset values, active value = 0.
